pps_divider_channel: RTL and testbench
======================================

Name: pps_divider_channel

Overview:
- One programmable output channel of the clock master.
- Consumes the PPS_DIV_* configuration registers produced by the SPI main-memory stage and generates a divided clock phase-aligned to the external PPS.
- Its output feeds the channel mux, which is steered by o_enable/o_selector.
- Four instances, one per mux channel.

Parameters:
- CNT_W, 32, width of period/high/phase counters (10 MHz ticks).
- SYNC_STAGES, 2, flip-flop stages on the asynchronous PPS input (minimum 2).

Ports:
- i_clk_10  in  1  10 MHz system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pps_raw  in  1  raw external PPS, asynchronous to i_clk_10.
- i_start  in  1  one-cycle pulse from the register write strobe: arm the channel.
- i_stop  in  1  one-cycle pulse: halt the channel.
- i_period  in  CNT_W  output period in ticks.
- i_high_time  in  CNT_W  high ticks per period.
- i_phase  in  CNT_W  delay in ticks from the PPS edge to the first rising edge.
- o_div_clk  out  1  divided output.
- o_busy  out  1  high in ARMED, PHASE or RUN.
- o_cfg_err  out  1  sticky; set on a rejected start, cleared by the next accepted start or by reset.
- o_pps_seen  out  1  one-cycle pulse on each synchronized PPS rising edge.

Behaviour:
- Reset (async assert, sync release): o_div_clk=0, o_busy=0, o_cfg_err=0, o_pps_seen=0, state=IDLE, counters=0, synchronizer flops=0.
- PPS path:
  - SYNC_STAGES flip-flops, then a rising-edge detect.
  - o_pps_seen asserts SYNC_STAGES+1 cycles after i_pps_raw rises.
- Configuration snapshot: i_period, i_high_time and i_phase are latched when i_start is accepted. Later register changes have no effect until the next start.
- Start validation: a start with i_period<2 is rejected. State is unchanged and o_cfg_err is set.
- State machine:
  - IDLE: on an accepted i_start, go to ARMED.
  - ARMED: on the PPS edge, go to PHASE with phase_cnt=0. If the snapshot phase is 0, go directly to RUN with o_div_clk=1 in the next cycle.
  - PHASE: phase_cnt increments each cycle. When phase_cnt==phase-1, go to RUN with per_cnt=0.
  - RUN:
    - per_cnt counts 0..period-1 and wraps to 0.
    - o_div_clk is registered, =1 while per_cnt<high_time.
    - high_time=0 gives a constant low output; high_time>=period gives a constant high output.
- Latency: the first o_div_clk rise is exactly phase+1 cycles after o_pps_seen.
- i_stop in any state: next cycle goes to IDLE, o_div_clk=0, counters cleared.
- Simultaneous events:
  - i_start with i_stop in the same cycle: stop wins and the start is discarded.
  - i_start while busy: it is a restart. The snapshot is reloaded and the state goes to ARMED, with o_div_clk=0 the next cycle.
  - PPS edge in the same cycle as an accepted start: the edge is not used; wait for the next PPS.
- Counters wrap only through the compare logic. No counter is ever allowed to overflow CNT_W.

Optional Feature:
- Macro PPS_DIV_RESYNC_EN.
- Defined: in RUN, every PPS edge re-enters the PHASE sequence from phase_cnt=0. This removes accumulated drift between the 10 MHz oscillator and GPS. o_div_clk is forced low during PHASE.
- Not defined: PPS is used only for the initial alignment in ARMED. PPS edges are ignored in RUN and the channel free-runs.

Decomposition:
- Shared package/header:
  - State encoding: IDLE=2'd0, ARMED=2'd1, PHASE=2'd2, RUN=2'd3.
  - Default CNT_W.
  - Minimum legal period constant (2).
- Sub-module pps_sync_edge: SYNC_STAGES synchronizer plus rising-edge detector. It is reused by other PPS consumers.

Test Plan:
- Reset: hold i_rst_n=0 and toggle i_pps_raw -> all outputs 0. Release reset -> outputs stay 0 with no start.
- Basic: period=10, high=5, phase=3, start, then PPS -> first rise at o_pps_seen+4 cycles, then a 5-high/5-low repeating pattern for 20 periods.
- Edge values:
  - period=1 -> start rejected, o_cfg_err=1, o_busy=0.
  - Then period=4, high=0 -> output constant low while busy.
  - Then high=7 -> output constant high.
- Stop mid-run: period=100, high=50, stop at per_cnt=20 -> o_div_clk=0 and o_busy=0 the next cycle. A restart re-arms and waits for the next PPS.
- Start+stop in the same cycle -> stays IDLE. A register change during RUN (period 10 to 20) -> output unchanged until re-start.
- Resync (PPS_DIV_RESYNC_EN defined): period=7, phase=2, two PPS edges 10000 cycles apart -> realignment at the second PPS (rise at o_pps_seen+3). Without the macro the output free-runs with no realignment.

Source files
------------

// File: rtl/pps_divider_channel_pkg.sv
// Shared types and constants for the PPS-aligned divider channel and its PPS front end.
package pps_divider_channel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PHASE = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   localparam int DEF_CNT_W       = 32;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int MIN_PERIOD      = 2;

endpackage

// File: rtl/pps_divider_channel_if.sv
// Control/config inputs and status outputs of one divider channel; master = register side, slave = channel.
interface pps_divider_channel_if
   import pps_divider_channel_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             i_start;
   logic             i_stop;
   logic [CNT_W-1:0] i_period;
   logic [CNT_W-1:0] i_high_time;
   logic [CNT_W-1:0] i_phase;
   logic             o_div_clk;
   logic             o_busy;
   logic             o_cfg_err;
   logic             o_pps_seen;

   modport master (
      output i_start, i_stop, i_period, i_high_time, i_phase,
      input  o_div_clk, o_busy, o_cfg_err, o_pps_seen
   );

   modport slave (
      input  i_start, i_stop, i_period, i_high_time, i_phase,
      output o_div_clk, o_busy, o_cfg_err, o_pps_seen
   );
endinterface

// File: rtl/pps_divider_channel_pps_sync_edge.sv
// PPS synchronizer plus registered rising-edge detect; pulse appears SYNC_STAGES+1 cycles after the input rises.
module pps_sync_edge
   import pps_divider_channel_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_pulse
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d  = sync_q[SYNC_STAGES-1];
      pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign edge_pulse = pulse_q;
endmodule

// File: rtl/pps_divider_channel.sv
// Programmable divided clock phase-aligned to PPS; first rise phase+1 cycles after o_pps_seen.
// Optional PPS_DIV_RESYNC_EN: every PPS edge in RUN restarts the phase sequence.
module pps_divider_channel
   import pps_divider_channel_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  i_clk_10,
   input  logic                  i_rst_n,
   input  logic                  i_pps_raw,
   pps_divider_channel_if.slave  ch
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             div_q, div_d;
   logic             err_q, err_d;

   logic             pps_edge;
   logic             start_ok;
   logic [CNT_W-1:0] run_nxt;
   state_e           align_state;
   logic             align_div;

   pps_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pps (
      .clk        (i_clk_10),
      .rst_n      (i_rst_n),
      .async_in   (i_pps_raw),
      .edge_pulse (pps_edge)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      err_d    = err_q;
      period_d = period_q;
      high_d   = high_q;
      phase_d  = phase_q;

      start_ok = ch.i_start && (ch.i_period >= CNT_W'(MIN_PERIOD));
      run_nxt  = (cnt_q == period_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);

      // Zero phase skips PHASE so the rise still lands phase+1 cycles after the pulse.
      align_state = (phase_q == '0) ? ST_RUN : ST_PHASE;
      align_div   = (phase_q == '0) && (high_q != '0);

      if (ch.i_stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         div_d   = 1'b0;
      end else if (start_ok) begin
         period_d = ch.i_period;
         high_d   = ch.i_high_time;
         phase_d  = ch.i_phase;
         state_d  = ST_ARMED;
         cnt_d    = '0;
         div_d    = 1'b0;
         err_d    = 1'b0;
      end else begin
         if (ch.i_start) begin
            err_d = 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               div_d = 1'b0;
            end
            ST_ARMED: begin
               if (pps_edge) begin
                  state_d = align_state;
                  cnt_d   = '0;
                  div_d   = align_div;
               end
            end
            ST_PHASE: begin
               div_d = 1'b0;
               if (cnt_q == phase_q - CNT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  div_d   = (high_q != '0);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
`ifdef PPS_DIV_RESYNC_EN
               if (pps_edge) begin
                  state_d = align_state;
                  cnt_d   = '0;
                  div_d   = align_div;
               end else
`endif
               begin
                  cnt_d = run_nxt;
                  div_d = (run_nxt < high_q);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               div_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         high_q   <= '0;
         phase_q  <= '0;
         div_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         phase_q  <= phase_d;
         div_q    <= div_d;
         err_q    <= err_d;
      end
   end

   assign ch.o_div_clk  = div_q;
   assign ch.o_busy     = (state_q != ST_IDLE);
   assign ch.o_cfg_err  = err_q;
   assign ch.o_pps_seen = pps_edge;
endmodule

// File: tb/tb_pps_divider_channel.sv
// Directed bench for pps_divider_channel; inputs driven and outputs sampled on the falling clock edge.
module tb_pps_divider_channel;
   localparam int R = 9995;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic pps_raw = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   errs;
   int   lat;
   logic seen2;

   pps_divider_channel_if #(.CNT_W(32)) ch ();

   pps_divider_channel #(.CNT_W(32), .SYNC_STAGES(2)) dut (
      .i_clk_10 (clk),
      .i_rst_n  (rst_n),
      .i_pps_raw(pps_raw),
      .ch       (ch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_ch(input int p, input int h, input int ph);
      ch.i_period    = p;
      ch.i_high_time = h;
      ch.i_phase     = ph;
      ch.i_start     = 1'b1;
      @(negedge clk);
      ch.i_start     = 1'b0;
   endtask

   task automatic stop_ch();
      ch.i_stop = 1'b1;
      @(negedge clk);
      ch.i_stop = 1'b0;
   endtask

   // Leaves the bench on the falling edge where o_pps_seen is high.
   task automatic pps_edge(input string tag);
      int n;
      pps_raw = 1'b0;
      repeat (4) @(negedge clk);
      pps_raw = 1'b1;
      lat = -1;
      n = 0;
      while (lat < 0 && n < 10) begin
         @(negedge clk);
         n++;
         if (ch.o_pps_seen) lat = n;
      end
      check(tag, lat, 3);
   endtask

   function automatic logic [3:0] outs();
      return {ch.o_div_clk, ch.o_busy, ch.o_cfg_err, ch.o_pps_seen};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      ch.i_start = 1'b0;
      ch.i_stop = 1'b0;
      ch.i_period = '0;
      ch.i_high_time = '0;
      ch.i_phase = '0;
      #2 rst_n = 1'b0;

      // reset with PPS toggling
      repeat (3) begin
         @(negedge clk) pps_raw = 1'b1;
         repeat (4) @(negedge clk);
         pps_raw = 1'b0;
      end
      repeat (4) @(negedge clk);
      check("rst_outs", outs(), 4'b0000);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_outs", outs(), 4'b0000);

      // basic: period 10, high 5, phase 3
      start_ch(10, 5, 3);
      check("basic_busy", ch.o_busy, 1'b1);
      check("basic_armed_low", ch.o_div_clk, 1'b0);
      pps_edge("basic_pps_lat");
      @(negedge clk);
      check("seen_one_cycle", ch.o_pps_seen, 1'b0);
      repeat (2) @(negedge clk);
      check("basic_phase_low", ch.o_div_clk, 1'b0);
      @(negedge clk);
      check("basic_first_rise", ch.o_div_clk, 1'b1);
      errs = 0;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== ((i % 10) < 5) || !ch.o_busy) errs++;
      end
      check("basic_pattern_errs", errs, 0);

      // rejected start, then high=0 and high>=period
      stop_ch();
      check("stop_outs", outs(), 4'b0000);
      start_ch(1, 0, 0);
      check("reject_err", ch.o_cfg_err, 1'b1);
      check("reject_busy", ch.o_busy, 1'b0);
      start_ch(4, 0, 0);
      check("accept_clears_err", ch.o_cfg_err, 1'b0);
      pps_edge("low_pps_lat");
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== 1'b0 || !ch.o_busy) errs++;
      end
      check("const_low_errs", errs, 0);
      start_ch(4, 7, 0);
      check("restart_low", ch.o_div_clk, 1'b0);
      pps_edge("high_pps_lat");
      @(negedge clk);
      check("high_first_rise", ch.o_div_clk, 1'b1);
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== 1'b1) errs++;
      end
      check("const_high_errs", errs, 0);

      // stop mid-run at per_cnt 20, then restart waits for next PPS
      start_ch(100, 50, 0);
      pps_edge("stop_pps_lat");
      @(negedge clk);
      repeat (20) @(negedge clk);
      check("stop_before", ch.o_div_clk, 1'b1);
      stop_ch();
      check("stop_div", ch.o_div_clk, 1'b0);
      check("stop_busy", ch.o_busy, 1'b0);
      start_ch(100, 50, 0);
      errs = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== 1'b0 || !ch.o_busy) errs++;
      end
      check("rearm_wait_errs", errs, 0);
      pps_edge("rearm_pps_lat");
      @(negedge clk);
      check("rearm_rise", ch.o_div_clk, 1'b1);

      // start and stop together
      stop_ch();
      ch.i_period = 10;
      ch.i_start = 1'b1;
      ch.i_stop = 1'b1;
      @(negedge clk);
      ch.i_start = 1'b0;
      ch.i_stop = 1'b0;
      check("start_stop_idle", ch.o_busy, 1'b0);

      // register change during RUN is ignored
      start_ch(10, 5, 0);
      pps_edge("regchg_pps_lat");
      @(negedge clk);
      check("regchg_rise", ch.o_div_clk, 1'b1);
      ch.i_period = 20;
      ch.i_high_time = 15;
      errs = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== ((i % 10) < 5)) errs++;
      end
      check("regchg_errs", errs, 0);

      // second PPS far away: resync or free-run
      stop_ch();
      start_ch(7, 3, 2);
      pps_edge("rs_pps_lat");
      repeat (2) @(negedge clk);
      check("rs_phase_low", ch.o_div_clk, 1'b0);
      @(negedge clk);
      check("rs_first_rise", ch.o_div_clk, 1'b1);
      errs = 0;
      seen2 = 1'b0;
      for (int i = 1; i <= R + 3; i++) begin
         @(negedge clk);
         if (ch.o_div_clk !== ((i % 7) < 3)) errs++;
         if (i == R + 3) seen2 = ch.o_pps_seen;
         if (i == 100) pps_raw = 1'b0;
         if (i == R) pps_raw = 1'b1;
      end
      check("rs_freerun_errs", errs, 0);
      check("rs_second_seen", seen2, 1'b1);
      errs = 0;
      for (int i = R + 4; i <= R + 40; i++) begin
         logic exp;
         @(negedge clk);
`ifdef PPS_DIV_RESYNC_EN
         exp = (i < R + 6) ? 1'b0 : (((i - (R + 6)) % 7) < 3);
`else
         exp = ((i % 7) < 3);
`endif
         if (ch.o_div_clk !== exp) errs++;
      end
      check("rs_after_errs", errs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
